// File: rtl/nes_clk_pkg.sv
// Shared types and default divide constants for the NES m2 clock recovery block.
package nes_clk_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } clkrec_state_t;

  localparam int NES_CPU_DIV = 24;
  localparam int NES_PPU_DIV = 8;
  localparam int NES_M2_HIGH = 8;

  typedef logic [4:0] phase_t;

  // Next phase with wrap from div-1 back to 0.
  function automatic phase_t phase_inc(input phase_t p, input int div);
    return (32'(p) == div - 1) ? '0 : p + 5'd1;
  endfunction

endpackage

// File: rtl/nes_m2_edge.sv
// m2 synchroniser and edge detector. With NES_CLKREC_GLITCH_FILTER_EN defined,
// a 3-sample majority filter sits between the synchroniser and m2_s so that
// single-cycle glitches never produce edges (one extra cycle of latency).
module nes_m2_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_m2,
  output logic o_m2_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_d;
  logic w_m2_s;

  // Two-flop synchroniser plus the delayed copy used for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_s1 <= i_m2;
      r_s2 <= r_s1;
      r_d  <= w_m2_s;
    end
  end

`ifdef NES_CLKREC_GLITCH_FILTER_EN
  logic r_f1, r_f2;

  // History of the synchronised value for the majority vote.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_f1 <= 1'b0;
      r_f2 <= 1'b0;
    end else begin
      r_f1 <= r_s2;
      r_f2 <= r_f1;
    end
  end

  assign w_m2_s = (r_s2 & r_f1) | (r_s2 & r_f2) | (r_f1 & r_f2);
`else
  assign w_m2_s = r_s2;
`endif

  assign o_m2_s = w_m2_s;
  assign o_rise = w_m2_s & ~r_d;
  assign o_fall = ~w_m2_s & r_d;

endmodule

// File: rtl/nes_clock_recover.sv
// Recovers the 24-phase CPU cycle position from m2 edges and regenerates
// phase-aligned CPU/PPU clock enables once m2 period and high time have been
// validated for LOCK_COUNT consecutive periods.
// Optional build macro: NES_CLKREC_GLITCH_FILTER_EN (majority filter on m2).
module nes_clock_recover
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV      = NES_CPU_DIV,
  parameter int PPU_DIV      = NES_PPU_DIV,
  parameter int M2_HIGH      = NES_M2_HIGH,
  parameter int RISE_PHASE   = 18,
  parameter int CPU_CE_PHASE = 7,
  parameter int LOCK_COUNT   = 4
) (
  input  logic       i_clk_master,
  input  logic       i_rst_master,
  input  logic       i_en,
  input  logic       i_m2,
  output logic [4:0] o_phase,
  output logic       o_cpu_ce,
  output logic       o_ppu_ce,
  output logic       o_locked,
  output logic [7:0] o_err_cnt
);

  localparam int CW      = $clog2(CPU_DIV + 3);
  localparam int GW      = $clog2(LOCK_COUNT + 1);
  localparam int PER_MAX = CPU_DIV + 2;
`ifdef NES_CLKREC_GLITCH_FILTER_EN
  // The filter delays edges by one cycle, so load one phase further on.
  localparam int LOAD_PHASE = (RISE_PHASE + 1) % CPU_DIV;
`else
  localparam int LOAD_PHASE = RISE_PHASE;
`endif

  clkrec_state_t   r_state;
  phase_t          r_phase;
  logic [CW-1:0]   r_per_cnt, r_hi_cnt;
  logic [GW-1:0]   r_good;
  logic [7:0]      r_err_cnt;
  logic            r_cpu_ce, r_ppu_ce;
  logic            w_m2_s, w_rise, w_fall;
  logic            w_locked, w_viol;

  nes_m2_edge u_edge (
    .i_clk  (i_clk_master),
    .i_rst  (i_rst_master),
    .i_m2   (i_m2),
    .o_m2_s (w_m2_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_locked = (r_state == LOCKED);

  // Any period, high-time or timeout violation while tracking drops to SEARCH;
  // it takes priority over a simultaneous rise.
  assign w_viol = (r_state != SEARCH) &&
                  ((w_rise  && (r_per_cnt != CW'(CPU_DIV))) ||
                   (w_fall  && (r_hi_cnt  != CW'(M2_HIGH))) ||
                   (!w_rise && (r_per_cnt == CW'(PER_MAX))));

  // Lock FSM, good-period counter and saturating lock-loss counter.
  always_ff @(posedge i_clk_master) begin
    if (i_rst_master) begin
      r_state   <= SEARCH;
      r_good    <= '0;
      r_err_cnt <= '0;
    end else if (i_en) begin
      if (w_viol) begin
        r_state <= SEARCH;
        r_good  <= '0;
        if (w_locked && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (w_rise) begin
        case (r_state)
          SEARCH: begin
            r_state <= TRACK;
            r_good  <= '0;
          end
          TRACK: begin
            r_good <= r_good + GW'(1);
            if (r_good == GW'(LOCK_COUNT - 1)) r_state <= LOCKED;
          end
          default: ;
        endcase
      end
    end
  end

  // Phase, period and high-time counters; rise reloads phase and period.
  always_ff @(posedge i_clk_master) begin
    if (i_rst_master) begin
      r_phase   <= '0;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (i_en) begin
      r_phase <= w_rise ? phase_t'(LOAD_PHASE) : phase_inc(r_phase, CPU_DIV);
      if (w_rise)                         r_per_cnt <= CW'(1);
      else if (r_per_cnt != CW'(PER_MAX)) r_per_cnt <= r_per_cnt + CW'(1);
      if (!w_m2_s)         r_hi_cnt <= '0;
      else if (~&r_hi_cnt) r_hi_cnt <= r_hi_cnt + CW'(1);
    end
  end

  // Registered strobes from the current phase, only while locked and enabled.
  always_ff @(posedge i_clk_master) begin
    if (i_rst_master) begin
      r_cpu_ce <= 1'b0;
      r_ppu_ce <= 1'b0;
    end else begin
      r_cpu_ce <= w_locked && i_en && (r_phase == phase_t'(CPU_CE_PHASE));
      r_ppu_ce <= w_locked && i_en && ((32'(r_phase) % PPU_DIV) == PPU_DIV - 1);
    end
  end

  assign o_phase   = r_phase;
  assign o_cpu_ce  = r_cpu_ce;
  assign o_ppu_ce  = r_ppu_ce;
  assign o_locked  = w_locked;
  assign o_err_cnt = r_err_cnt;

endmodule
